// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pkg
//  Description : Shared definitions for the systolic array sequencer: default
//                array dimension and vector-count width, plus the sequencer
//                state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package systolic_pkg;

    localparam int c_n_default  = 4;   // array dimension (rows = columns)
    localparam int c_kw_default = 8;   // width of k_len and the feed counter

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_FEED  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_counter
//  Description : W-bit up-counter with synchronous clear (priority over
//                enable) and asynchronous active-low reset.
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous active-low reset
//                clr   - synchronous clear to zero
//                en    - count enable
//                count - current count value
//  Revision    : 1.0  initial release
// ============================================================================
module seq_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/systolic_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_sequencer
//  Description : Control sequencer for an N x N systolic array. One pass runs
//                CLEAR -> LOAD (N weight rows) -> FEED (k_len + 2N - 2 skewed
//                cycles) -> DRAIN (N result columns) -> DONE. All outputs are
//                decoded from the registered state and the shared counter.
//  Ports       : clk       - rising-edge clock
//                reset     - asynchronous active-low reset
//                start     - run request, honoured only in IDLE
//                k_len     - input vector count, captured on accepted start
//                busy      - high outside IDLE
//                done      - one-cycle completion pulse
//                acc_clr   - PE accumulator clear
//                load_en   - weight register enable
//                load_row  - weight row being loaded
//                rd_addr   - input buffer read index (feed counter t)
//                row_valid - skewed per-row input valid
//                out_valid - result column present on array outputs
//                out_col   - result column being drained
//  Revision    : 1.0  initial release
// ============================================================================
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int N  = c_n_default,
    parameter int KW = c_kw_default
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    output logic                 busy,
    output logic                 done,
    output logic                 acc_clr,
    output logic                 load_en,
    output logic [$clog2(N)-1:0] load_row,
    output logic [KW-1:0]        rd_addr,
    output logic [N-1:0]         row_valid,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] out_col
);

    localparam int CW = $clog2(N);

    // Counter values are one bit wider than k_len so that the last feed
    // index k_len + 2N - 3 never wraps, even at k_len = 2^KW - 1.
    localparam logic [KW:0] c_last_nm1  = (KW+1)'(N - 1);
    localparam logic [KW:0] c_feed_tail = (KW+1)'(2 * N - 3);

    state_t        r_state;
    state_t        w_next;
    logic [KW-1:0] r_klen;
    logic [KW:0]   w_cnt;
    logic          w_cnt_clr;
    logic          w_cnt_en;
    logic [KW:0]   w_feed_last;
    logic          w_in_feed;

    assign w_feed_last = {1'b0, r_klen} + c_feed_tail;
    assign w_in_feed   = (r_state == ST_FEED);

    // One counter serves LOAD, FEED and DRAIN; it is cleared on every phase
    // boundary so each phase starts counting from zero.
    seq_counter #(
        .W (KW + 1)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_cnt_clr),
        .en    (w_cnt_en),
        .count (w_cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // k_len is sampled only when a pass is accepted and then held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_klen <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_klen <= k_len;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_clr = 1'b1;
        w_cnt_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_cnt == c_last_nm1) begin
                    w_next = (r_klen == '0) ? ST_DRAIN : ST_FEED;
                end else begin
                    w_cnt_clr = 1'b0;
                    w_cnt_en  = 1'b1;
                end
            end
            ST_FEED: begin
                if (w_cnt == w_feed_last) begin
                    w_next = ST_DRAIN;
                end else begin
                    w_cnt_clr = 1'b0;
                    w_cnt_en  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_cnt == c_last_nm1) begin
                    w_next = ST_DONE;
                end else begin
                    w_cnt_clr = 1'b0;
                    w_cnt_en  = 1'b1;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (r_state != ST_IDLE);
        done      = 1'b0;
        acc_clr   = 1'b0;
        load_en   = 1'b0;
        load_row  = '0;
        rd_addr   = '0;
        out_valid = 1'b0;
        out_col   = '0;
        case (r_state)
            ST_CLEAR: acc_clr = 1'b1;
            ST_LOAD: begin
                load_en  = 1'b1;
                load_row = w_cnt[CW-1:0];
            end
            ST_FEED: rd_addr = w_cnt[KW-1:0];
            ST_DRAIN: begin
                out_valid = 1'b1;
                out_col   = w_cnt[CW-1:0];
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Row i sees the input wavefront i cycles late and stays valid for
    // exactly k_len cycles.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_row
            assign row_valid[gi] = w_in_feed
                                 && (w_cnt >= (KW+1)'(gi))
                                 && ((w_cnt - (KW+1)'(gi)) < {1'b0, r_klen});
        end
    endgenerate

endmodule
`default_nettype wire
